maxpool_engine: RTL and testbench

- Layer-1 stage directly downstream of the layer-0 convolution/ReLU stage.
- Reads the 64x64 layer-0 feature map from the L0 memory bank (csel=001), computes non-overlapping 2x2 max-pooling with stride 2, and writes the 32x32 result to the L1 bank (csel=011).
- Uses the same crd/cwr/csel memory protocol as the conv stage; the top-level controller starts it once layer 0 is complete.

---
 rtl/maxpool_engine.sv | 182 ++++++++++++++++++
 tb/tb_maxpool_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/maxpool_engine.sv
// maxpool_engine: non-overlapping 2x2 / stride-2 max-pooling of an IMG_W x IMG_W
// feature map held in the L0 bank, writing the (IMG_W/2)^2 result to the L1 bank.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle request to begin pooling (ignored while busy or in DONE)
//   busy      high while pooling is in progress
//   done      one-cycle pulse after the last write
//   crd       memory read enable
//   caddr_rd  read address into L0
//   cdata_rd  read data (combinational response within the crd cycle)
//   cwr       memory write enable
//   caddr_wr  write address into L1
//   cdata_wr  write data
//   csel      bank select (RD_SEL while reading, WR_SEL while writing, else 0)
//
// Every output is a register loaded with the value belonging to the state being
// entered, so outputs change only at clock edges (or on reset).
module maxpool_engine #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned DW     = 20,
  parameter logic [2:0]  RD_SEL = 3'b001,
  parameter logic [2:0]  WR_SEL = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [11:0]   caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [11:0]   caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int unsigned AW = 12;
  localparam int unsigned PW = $clog2(IMG_W) - 1;  // pool row/column index width

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR, DONE} state_t;

  state_t         state, state_n;
  logic [PW-1:0]  r, r_n, c, c_n;
  logic [DW-1:0]  mx, mx_n, mx_upd;

  logic           busy_n, done_n, crd_n, cwr_n;
  logic [AW-1:0]  caddr_rd_n, caddr_wr_n;
  logic [DW-1:0]  cdata_wr_n;
  logic [2:0]     csel_n;

  // L0 address of element k of pool block (rr,cc): row 2rr+k[1], column 2cc+k[0].
  function automatic logic [AW-1:0] rd_addr(input logic [PW-1:0] rr,
                                            input logic [PW-1:0] cc,
                                            input logic [1:0]    k);
    return AW'({rr, k[1], cc, k[0]});
  endfunction

  function automatic logic [AW-1:0] wr_addr(input logic [PW-1:0] rr,
                                            input logic [PW-1:0] cc);
    return AW'({rr, cc});
  endfunction

  assign mx_upd = ($signed(cdata_rd) > $signed(mx)) ? cdata_rd : mx;

  always_comb begin
    state_n    = state;
    r_n        = r;
    c_n        = c;
    mx_n       = mx;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    crd_n      = 1'b0;
    cwr_n      = 1'b0;
    csel_n     = '0;
    caddr_rd_n = caddr_rd;
    caddr_wr_n = caddr_wr;
    cdata_wr_n = cdata_wr;

    unique case (state)
      IDLE: begin
        r_n = '0;
        c_n = '0;
        if (start) begin
          state_n    = RD0;
          busy_n     = 1'b1;
          crd_n      = 1'b1;
          csel_n     = RD_SEL;
          caddr_rd_n = rd_addr('0, '0, 2'd0);
        end
      end
      RD0: begin
        mx_n       = cdata_rd;
        state_n    = RD1;
        busy_n     = 1'b1;
        crd_n      = 1'b1;
        csel_n     = RD_SEL;
        caddr_rd_n = rd_addr(r, c, 2'd1);
      end
      RD1: begin
        mx_n       = mx_upd;
        state_n    = RD2;
        busy_n     = 1'b1;
        crd_n      = 1'b1;
        csel_n     = RD_SEL;
        caddr_rd_n = rd_addr(r, c, 2'd2);
      end
      RD2: begin
        mx_n       = mx_upd;
        state_n    = RD3;
        busy_n     = 1'b1;
        crd_n      = 1'b1;
        csel_n     = RD_SEL;
        caddr_rd_n = rd_addr(r, c, 2'd3);
      end
      RD3: begin
        // Final compare feeds the write-data register directly so the
        // result is on cdata_wr during the WR cycle.
        mx_n       = mx_upd;
        state_n    = WR;
        busy_n     = 1'b1;
        cwr_n      = 1'b1;
        csel_n     = WR_SEL;
        caddr_wr_n = wr_addr(r, c);
        cdata_wr_n = mx_upd;
      end
      WR: begin
        c_n = c + 1'b1;
        if (c == '1) r_n = r + 1'b1;
        if ((r == '1) && (c == '1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n    = RD0;
          busy_n     = 1'b1;
          crd_n      = 1'b1;
          csel_n     = RD_SEL;
          caddr_rd_n = rd_addr(r_n, c_n, 2'd0);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      r        <= '0;
      c        <= '0;
      mx       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= '0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      state    <= state_n;
      r        <= r_n;
      c        <= c_n;
      mx       <= mx_n;
      busy     <= busy_n;
      done     <= done_n;
      crd      <= crd_n;
      cwr      <= cwr_n;
      csel     <= csel_n;
      caddr_rd <= caddr_rd_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
    end
  end

endmodule

// File: tb/tb_maxpool_engine.sv
// tb_maxpool_engine: self-checking bench for maxpool_engine. Models the L0/L1
// banks as arrays, and checks the L1 contents against a plain 2x2 signed-max
// reference, plus cycle counts, address order and bus protocol per run.
module tb_maxpool_engine;

  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int PO    = IMG_W / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0 [IMG_W*IMG_W];
  logic [DW-1:0] l1 [PO*PO];
  logic          clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  maxpool_engine #(.IMG_W(IMG_W), .DW(DW), .RD_SEL(3'b001), .WR_SEL(3'b011)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  assign cdata_rd = l0[caddr_rd];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < PO*PO; i++) l1[i] <= 20'hABCDE;
    end else if (cwr) begin
      l1[caddr_wr[9:0]] <= cdata_wr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed maximum of the 2x2 window at pool position (r,c).
  function automatic logic [DW-1:0] ref_max(input int r, input int c);
    logic signed [DW-1:0] best, v;
    best = l0[(2*r)*IMG_W + 2*c];
    for (int k = 1; k < 4; k++) begin
      v = l0[(2*r + k/2)*IMG_W + 2*c + k%2];
      if (v > best) best = v;
    end
    return best;
  endfunction

  function automatic int exp_rd(input int n);
    int blk, k, r, c;
    blk = n / 4;
    k   = n % 4;
    r   = blk / PO;
    c   = blk % PO;
    return (2*r + k/2)*IMG_W + 2*c + k%2;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_crd"}, crd, 0);
    chk({tag, "_cwr"}, cwr, 0);
    chk({tag, "_csel"}, csel, 0);
    chk({tag, "_caddr_rd"}, caddr_rd, 0);
    chk({tag, "_caddr_wr"}, caddr_wr, 0);
    chk({tag, "_cdata_wr"}, cdata_wr, 0);
  endtask

  // One pooling pass. extra_at: cycle on which a stray start is pulsed.
  // abort_at: cycle on which reset is asserted mid-cycle (0 = never).
  task automatic run_pool(input string name, input int extra_at, input int abort_at);
    int cyc, nrd, nwr, nbusy, done_cyc, ri, wi;
    bit addr_ok, proto_ok;
    nrd = 0; nwr = 0; nbusy = 0; done_cyc = -1; ri = 0; wi = 0;
    addr_ok = 1'b1; proto_ok = 1'b1;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (cyc = 1; cyc <= 6000; cyc++) begin
      if (cyc == abort_at) begin
        #1 reset = 1'b0;
        #1 check_zero({name, "_abort"});
        @(negedge clk); reset = 1'b1;
        return;
      end
      if (crd && cwr) proto_ok = 1'b0;
      if (crd && csel != 3'b001) proto_ok = 1'b0;
      if (cwr && csel != 3'b011) proto_ok = 1'b0;
      if (!busy && (crd || cwr || csel != 3'b000)) proto_ok = 1'b0;
      if (busy) nbusy++;
      if (crd) begin
        if (int'(caddr_rd) != exp_rd(ri)) addr_ok = 1'b0;
        ri++; nrd++;
      end
      if (cwr) begin
        if (int'(caddr_wr) != wi) addr_ok = 1'b0;
        wi++; nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == extra_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, "_done_cycle"}, done_cyc, 5121);
    chk({name, "_busy_cycles"}, nbusy, 5120);
    chk({name, "_reads"}, nrd, 4096);
    chk({name, "_writes"}, nwr, 1024);
    chk({name, "_addr_order"}, addr_ok, 1);
    chk({name, "_protocol"}, proto_ok, 1);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_csel"}, csel, 0);
    for (int r = 0; r < PO; r++)
      for (int c = 0; c < PO; c++)
        chk($sformatf("%s_l1[%0d]", name, r*PO + c), l1[r*PO + c], ref_max(r, c));
  endtask

  initial begin
    #2 check_zero("reset");
    @(negedge clk); reset = 1'b1;

    // Ramp map
    for (int i = 0; i < IMG_W*IMG_W; i++) l0[i] = DW'(i);
    run_pool("ramp", 0, 0);
    chk("ramp_first", l1[0], 65);
    chk("ramp_last", l1[PO*PO-1], 4095);

    // Position sweep: one 0x10000 per block, rotating offset
    for (int i = 0; i < IMG_W*IMG_W; i++) l0[i] = '0;
    for (int b = 0; b < PO*PO; b++) begin
      int k = b % 4;
      l0[(2*(b/PO) + k/2)*IMG_W + 2*(b%PO) + k%2] = 20'h10000;
    end
    run_pool("sweep", 0, 0);
    chk("sweep_517", l1[517], 32'h10000);

    // Corner element only
    for (int i = 0; i < IMG_W*IMG_W; i++) l0[i] = '0;
    l0[IMG_W*IMG_W-1] = 20'h00001;
    run_pool("corner", 0, 0);
    chk("corner_1023", l1[PO*PO-1], 1);

    // Random map with signed corner cases in blocks 0..2, stray start at cycle 100
    for (int i = 0; i < IMG_W*IMG_W; i++) l0[i] = DW'($urandom);
    l0[0] = 20'hFFFFF; l0[1] = 20'h80000; l0[64] = 20'h00000; l0[65] = 20'hFFFFE;
    l0[2] = 20'h80000; l0[3] = 20'h80000; l0[66] = 20'h80000; l0[67] = 20'h80000;
    l0[4] = 20'h7FFFF; l0[5] = 20'h80000; l0[68] = 20'h00000; l0[69] = 20'h00000;
    run_pool("signed", 100, 0);
    chk("signed_blk0", l1[0], 32'h00000);
    chk("signed_blk1", l1[1], 32'h80000);
    chk("signed_blk2", l1[2], 32'h7FFFF);

    // Async reset mid-run (cycle 2003 is an RD2 cycle), then a clean full run
    for (int i = 0; i < IMG_W*IMG_W; i++) l0[i] = DW'($urandom);
    run_pool("abort", 0, 2003);
    run_pool("rerun", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
